// File: rtl/program_memory_arbiter.sv
// Two-master Wishbone classic arbiter sharing the program memory read port
// between instruction fetch (m0) and load/store (m1), with a cycle watchdog.
module program_memory_arbiter #(
  parameter logic [31:0] BaseAddr      = 32'h0,
  parameter bit          RoundRobin    = 1'b1,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic        clk_in,
  input  logic        reset_in,
  // master 0: instruction fetch
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1: data load/store
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // slave: program memory
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StTout = 2'd2;

  localparam logic [8:0] TimeoutLimit = 9'(TimeoutCycles);
  localparam bit         WatchdogOn   = (TimeoutCycles != 0);

  logic [1:0] state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] wd_q, wd_d;
  logic [8:0] wd_next;
  logic       busy, tout, gnt_stb, term, wd_expire;
  logic       unused_base;

  // Addresses pass through untranslated; the base is informational only.
  assign unused_base = ^BaseAddr;

  assign busy      = (state_q == StBusy);
  assign tout      = (state_q == StTout);
  assign gnt_stb   = grant_q ? m1_stb_i : m0_stb_i;
  assign term      = s_ack_i | s_err_i;
  assign wd_next   = {1'b0, wd_q} + 9'd1;
  assign wd_expire = WatchdogOn && (wd_next == TimeoutLimit);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    case (state_q)
      StIdle: begin
        if (m0_stb_i || m1_stb_i) begin
          state_d = StBusy;
          wd_d    = '0;
          if (m0_stb_i && m1_stb_i) grant_d = RoundRobin ? ~last_grant_q : 1'b0;
          else                      grant_d = m1_stb_i;
        end
      end
      StBusy: begin
        // Slave termination beats both an abort and a same-cycle watchdog expiry.
        if (term) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end else if (!gnt_stb) begin
          state_d = StIdle;
        end else if (wd_expire) begin
          state_d = StTout;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      StTout: begin
        state_d      = StIdle;
        last_grant_d = grant_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: registers are updated with non-blocking assignments only.
    if (reset_in) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
    end
  end

  assign s_stb_o   = busy & gnt_stb;
  assign s_we_o    = grant_q ? m1_we_i    : m0_we_i;
  assign s_addr_o  = grant_q ? m1_addr_i  : m0_addr_i;
  assign s_wdata_o = grant_q ? m1_wdata_i : m0_wdata_i;

  // Responses reach only the granted master; TOUT fabricates the error.
  assign m0_ack_o = busy & ~grant_q & s_ack_i;
  assign m1_ack_o = busy &  grant_q & s_ack_i;
  assign m0_err_o = ~grant_q & ((busy & s_err_i) | tout);
  assign m1_err_o =  grant_q & ((busy & s_err_i) | tout);

  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench: instance 0 is round-robin with a 4-cycle watchdog,
// instance 1 is fixed priority with the watchdog disabled.
module tb_program_memory_arbiter;

  logic clk_in = 1'b0;
  logic reset_in;

  logic        m0_stb [2], m0_we [2], m1_stb [2], m1_we [2], noack [2];
  logic [31:0] m0_addr [2], m0_wdata [2], m1_addr [2], m1_wdata [2];
  logic [31:0] m0_rdata [2], m1_rdata [2], s_addr [2], s_wdata [2];
  logic        m0_ack [2], m0_err [2], m1_ack [2], m1_err [2], s_stb [2], s_we [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_in = ~clk_in;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] mem_word, s_rdata;
    logic        s_ack = 1'b0;
    logic        s_err;

    // Memory stub: errors on writes/misaligned at once, acks reads a cycle later.
    assign s_err    = s_stb[g] && !noack[g] && (s_we[g] || (s_addr[g][1:0] != 2'b00));
    assign mem_word = 32'h0102_0300 | {28'd0, s_addr[g][5:2]};
    assign s_rdata  = {mem_word[7:0], mem_word[15:8], mem_word[23:16], mem_word[31:24]};
    always @(posedge clk_in) s_ack <= s_stb[g] && !s_err && !s_ack && !noack[g];

    program_memory_arbiter #(
      .BaseAddr     (32'h0),
      .RoundRobin   (g == 0),
      .TimeoutCycles(g == 0 ? 4 : 0)
    ) u_dut (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .m0_stb_i  (m0_stb[g]),
      .m0_we_i   (m0_we[g]),
      .m0_addr_i (m0_addr[g]),
      .m0_wdata_i(m0_wdata[g]),
      .m0_rdata_o(m0_rdata[g]),
      .m0_ack_o  (m0_ack[g]),
      .m0_err_o  (m0_err[g]),
      .m1_stb_i  (m1_stb[g]),
      .m1_we_i   (m1_we[g]),
      .m1_addr_i (m1_addr[g]),
      .m1_wdata_i(m1_wdata[g]),
      .m1_rdata_o(m1_rdata[g]),
      .m1_ack_o  (m1_ack[g]),
      .m1_err_o  (m1_err[g]),
      .s_stb_o   (s_stb[g]),
      .s_we_o    (s_we[g]),
      .s_addr_o  (s_addr[g]),
      .s_wdata_o (s_wdata[g]),
      .s_rdata_i (s_rdata),
      .s_ack_i   (s_ack),
      .s_err_i   (s_err)
    );
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    m0_addr[0] = 32'h40;
    m1_addr[0] = 32'h80;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({s_stb[i], m0_ack[i], m0_err[i], m1_ack[i], m1_err[i]} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs inst=%0d got=%b exp=00000", i,
                 {s_stb[i], m0_ack[i], m0_err[i], m1_ack[i], m1_err[i]});
      end
    end
    n_tests++;
    if (s_addr[0] !== 32'h40) begin
      n_fail++; $display("FAIL reset_addr_follows_m0 got=%h exp=00000040", s_addr[0]);
    end
    reset_in = 1'b0;
    m0_addr[0] = 32'h0;
    m1_addr[0] = 32'h0;
    tick();
  endtask

  task automatic test_single_fetch();
    m0_addr[0] = 32'h10;
    m0_stb[0]  = 1'b1;
    n_tests++;
    if (s_stb[0] !== 1'b0) begin n_fail++; $display("FAIL fetch_stb_before got=%b exp=0", s_stb[0]); end
    tick();
    n_tests++;
    if ({s_stb[0], m0_ack[0]} !== 2'b10 || s_addr[0] !== 32'h10) begin
      n_fail++; $display("FAIL fetch_busy stb/ack=%b addr=%h exp=10/00000010", {s_stb[0], m0_ack[0]}, s_addr[0]);
    end
    tick();
    n_tests++;
    if (m0_ack[0] !== 1'b1 || m0_rdata[0] !== 32'h0403_0201) begin
      n_fail++; $display("FAIL fetch_ack ack=%b rdata=%h exp=1/04030201", m0_ack[0], m0_rdata[0]);
    end
    n_tests++;
    if ({m1_ack[0], m1_err[0], m0_err[0]} !== 3'b0) begin
      n_fail++; $display("FAIL fetch_others got=%b exp=000", {m1_ack[0], m1_err[0], m0_err[0]});
    end
    m0_stb[0] = 1'b0;
    tick();
    n_tests++;
    if ({s_stb[0], m0_ack[0]} !== 2'b00) begin
      n_fail++; $display("FAIL fetch_idle got=%b exp=00", {s_stb[0], m0_ack[0]});
    end
  endtask

  // Both masters hold stb; each transfer is BUSY, ack, IDLE.
  task automatic run_contention(input int idx, input int n_xfer);
    logic       exp_m1;
    logic [1:0] acks;
    pulse_reset();
    m0_addr[idx] = 32'h0;
    m1_addr[idx] = 32'h8;
    m0_stb[idx]  = 1'b1;
    m1_stb[idx]  = 1'b1;
    for (int k = 0; k < n_xfer; k++) begin
      exp_m1 = (idx == 0) ? k[0] : 1'b0;
      tick();
      n_tests++;
      if (s_stb[idx] !== 1'b1 || s_addr[idx] !== (exp_m1 ? 32'h8 : 32'h0)) begin
        n_fail++; $display("FAIL contention_grant inst=%0d xfer=%0d stb=%b addr=%h exp_m1=%b",
                           idx, k, s_stb[idx], s_addr[idx], exp_m1);
      end
      tick();
      acks = {m1_ack[idx], m0_ack[idx]};
      n_tests++;
      if (acks !== (exp_m1 ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contention_ack inst=%0d xfer=%0d got=%b exp=%b",
                           idx, k, acks, exp_m1 ? 2'b10 : 2'b01);
      end
      if (k == n_xfer - 1) begin
        m0_stb[idx] = 1'b0;
        m1_stb[idx] = 1'b0;
      end
      tick();
      n_tests++;
      if (s_stb[idx] !== 1'b0) begin
        n_fail++; $display("FAIL contention_gap inst=%0d xfer=%0d stb=%b exp=0", idx, k, s_stb[idx]);
      end
    end
  endtask

  task automatic test_round_robin();
    run_contention(0, 4);
  endtask

  task automatic test_fixed_priority();
    run_contention(1, 3);
  endtask

  task automatic test_error_passthrough();
    m1_addr[0] = 32'h4;
    m1_we[0]   = 1'b1;
    m1_stb[0]  = 1'b1;
    tick();
    n_tests++;
    if ({m1_err[0], m1_ack[0], m0_err[0], m0_ack[0]} !== 4'b1000) begin
      n_fail++; $display("FAIL err_pass got=%b exp=1000", {m1_err[0], m1_ack[0], m0_err[0], m0_ack[0]});
    end
    m1_stb[0] = 1'b0;
    m1_we[0]  = 1'b0;
    tick();
    n_tests++;
    if ({s_stb[0], m1_err[0]} !== 2'b00) begin
      n_fail++; $display("FAIL err_idle got=%b exp=00", {s_stb[0], m1_err[0]});
    end
  endtask

  task automatic test_watchdog();
    noack[0]   = 1'b1;
    m0_addr[0] = 32'h0;
    m0_stb[0]  = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({s_stb[0], m0_err[0]} !== 2'b10) begin
        n_fail++; $display("FAIL wd_wait cyc=%0d got=%b exp=10", k, {s_stb[0], m0_err[0]});
      end
      tick();
    end
    n_tests++;
    if ({m0_err[0], m0_ack[0], s_stb[0], m1_err[0]} !== 4'b1000) begin
      n_fail++; $display("FAIL wd_tout got=%b exp=1000", {m0_err[0], m0_ack[0], s_stb[0], m1_err[0]});
    end
    m0_stb[0] = 1'b0;
    tick();
    n_tests++;
    if (m0_err[0] !== 1'b0) begin n_fail++; $display("FAIL wd_err_width got=%b exp=0", m0_err[0]); end
    noack[0] = 1'b0;

    noack[1]  = 1'b1;
    m0_stb[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if ({s_stb[1], m0_err[1]} !== 2'b10) begin
        n_fail++; $display("FAIL wd_disabled_hold cyc=%0d got=%b exp=10", k, {s_stb[1], m0_err[1]});
      end
    end
    m0_stb[1] = 1'b0;
    tick();
    noack[1] = 1'b0;
  endtask

  task automatic test_reset_mid_transfer();
    m0_addr[0] = 32'h10;
    m1_addr[0] = 32'h8;
    m0_stb[0]  = 1'b1;
    tick();
    n_tests++;
    if (s_stb[0] !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=1", s_stb[0]); end
    reset_in = 1'b1;
    tick();
    n_tests++;
    if ({s_stb[0], m0_ack[0], m0_err[0], m1_ack[0], m1_err[0]} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_drop got=%b exp=00000",
                         {s_stb[0], m0_ack[0], m0_err[0], m1_ack[0], m1_err[0]});
    end
    reset_in  = 1'b0;
    m1_stb[0] = 1'b1;
    tick();
    n_tests++;
    if (s_stb[0] !== 1'b1 || s_addr[0] !== 32'h10) begin
      n_fail++; $display("FAIL rst_first_tie stb=%b addr=%h exp=1/00000010", s_stb[0], s_addr[0]);
    end
    tick();
    n_tests++;
    if ({m0_ack[0], m1_ack[0]} !== 2'b10) begin
      n_fail++; $display("FAIL rst_tie_ack got=%b exp=10", {m0_ack[0], m1_ack[0]});
    end
    m0_stb[0] = 1'b0;
    m1_stb[0] = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    // m1 completes so last_grant becomes m1.
    m1_addr[0] = 32'h8;
    m1_stb[0]  = 1'b1;
    tick();
    tick();
    n_tests++;
    if (m1_ack[0] !== 1'b1) begin n_fail++; $display("FAIL abort_setup_ack got=%b exp=1", m1_ack[0]); end
    m1_stb[0] = 1'b0;
    tick();
    // m0 aborts; a following tie must still favour m0.
    noack[0]   = 1'b1;
    m0_addr[0] = 32'h10;
    m0_stb[0]  = 1'b1;
    tick();
    m0_stb[0] = 1'b0;
    tick();
    n_tests++;
    if ({s_stb[0], m0_ack[0], m0_err[0]} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle got=%b exp=000", {s_stb[0], m0_ack[0], m0_err[0]});
    end
    noack[0]  = 1'b0;
    m0_stb[0] = 1'b1;
    m1_stb[0] = 1'b1;
    tick();
    n_tests++;
    if (s_addr[0] !== 32'h10) begin
      n_fail++; $display("FAIL abort_last_grant_kept addr=%h exp=00000010", s_addr[0]);
    end
    tick();
    m0_stb[0] = 1'b0;
    m1_stb[0] = 1'b0;
    tick();
    // m0 aborts while m1 is pending; m1 is served next.
    noack[0]  = 1'b1;
    m0_stb[0] = 1'b1;
    tick();
    m0_stb[0] = 1'b0;
    m1_stb[0] = 1'b1;
    tick();
    n_tests++;
    if (s_stb[0] !== 1'b0) begin n_fail++; $display("FAIL abort2_idle got=%b exp=0", s_stb[0]); end
    noack[0] = 1'b0;
    tick();
    n_tests++;
    if (s_stb[0] !== 1'b1 || s_addr[0] !== 32'h8) begin
      n_fail++; $display("FAIL abort2_m1_grant stb=%b addr=%h exp=1/00000008", s_stb[0], s_addr[0]);
    end
    tick();
    n_tests++;
    if ({m1_ack[0], m0_ack[0]} !== 2'b10) begin
      n_fail++; $display("FAIL abort2_m1_ack got=%b exp=10", {m1_ack[0], m0_ack[0]});
    end
    m1_stb[0] = 1'b0;
    tick();
  endtask

  initial begin
    reset_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m0_stb[i] = 1'b0; m0_we[i] = 1'b0; m0_addr[i] = '0; m0_wdata[i] = 32'hA5A5_0000;
      m1_stb[i] = 1'b0; m1_we[i] = 1'b0; m1_addr[i] = '0; m1_wdata[i] = 32'h5A5A_0000;
      noack[i]  = 1'b0;
    end
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_fixed_priority();
    test_error_passthrough();
    test_watchdog();
    test_reset_mid_transfer();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
